// File: rtl/req_arbiter_pkg.sv
// Shared types and default sizing for the request arbiter.
// No logic here, so no latency and no backpressure.
package req_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OWNED = 1'b1
  } arb_state_t;

  localparam int ARB_N_DEF        = 4;
  localparam int ARB_MAX_HOLD_DEF = 16;
  localparam int ARB_HOLD_W       = 8;

endpackage

// File: rtl/req_arbiter_arb_pick.sv
// Highest-index priority picker over an already masked request vector.
// Purely combinational (0 cycles); no backpressure.
module arb_pick #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] req,
  output logic [N-1:0]    idx,
  output logic            vld
);

  localparam int R = 2**N;

  // Ascending scan: the last hit is the highest asserted index.
  always_comb begin
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (req[i]) begin
        idx = N'(i);
        vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/req_arbiter.sv
// Grant arbiter for 2**N requesters with a MAX_HOLD ownership limit; ARB_ROUND_ROBIN_EN picks round robin.
// Grant registered 1 cycle after arbitration; requesters simply hold req until granted (no backpressure).
module req_arbiter
  import req_arbiter_pkg::*;
#(
  parameter int N        = ARB_N_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [2**N-1:0] req,
  output logic [2**N-1:0] gnt,
  output logic [N-1:0]    gnt_id,
  output logic            gnt_valid,
  output logic            timeout
);

  localparam int R = 2**N;

  arb_state_t            state, state_nxt;
  logic [R-1:0]          gnt_nxt;
  logic [N-1:0]          id_nxt;
  logic [ARB_HOLD_W-1:0] hold_cnt, hold_nxt;
  logic                  timeout_nxt;
  logic [R-1:0]          excl, excl_nxt;
  logic [R-1:0]          cand;
  logic [N-1:0]          win_id;
  logic                  win_vld;

  // An expired owner only steps aside when someone else is asking.
  always_comb begin
    cand = req & ~excl;
    if (cand == '0) cand = req;
  end

`ifdef ARB_ROUND_ROBIN_EN
  logic [N-1:0] ptr, ptr_nxt;
  logic [R-1:0] below;
  logic [N-1:0] lo_id, all_id;
  logic         lo_vld, all_vld;

  always_comb begin
    below = '0;
    for (int i = 0; i < R; i++) below[i] = (N'(i) < ptr);
  end

  arb_pick #(.N(N)) u_pick_lo  (.req(cand & below), .idx(lo_id),  .vld(lo_vld));
  arb_pick #(.N(N)) u_pick_all (.req(cand),         .idx(all_id), .vld(all_vld));

  // Nothing below the pointer wraps around to the top of the vector.
  assign win_id  = lo_vld ? lo_id : all_id;
  assign win_vld = all_vld;

  always_comb begin
    ptr_nxt = ptr;
    if (state == IDLE && win_vld) ptr_nxt = win_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end
`else
  arb_pick #(.N(N)) u_pick (.req(cand), .idx(win_id), .vld(win_vld));
`endif

  always_comb begin
    state_nxt   = state;
    gnt_nxt     = gnt;
    id_nxt      = gnt_id;
    hold_nxt    = hold_cnt;
    timeout_nxt = 1'b0;
    excl_nxt    = excl;
    case (state)
      IDLE: begin
        if (win_vld) begin
          state_nxt = OWNED;
          gnt_nxt   = R'(1) << win_id;
          id_nxt    = win_id;
          hold_nxt  = ARB_HOLD_W'(1);
          excl_nxt  = '0;
        end
      end
      OWNED: begin
        // Release wins over the hold limit when both land in one cycle.
        if (!req[gnt_id]) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          id_nxt    = '0;
          hold_nxt  = '0;
        end else if (hold_cnt == ARB_HOLD_W'(MAX_HOLD)) begin
          state_nxt   = IDLE;
          gnt_nxt     = '0;
          id_nxt      = '0;
          hold_nxt    = '0;
          timeout_nxt = 1'b1;
          excl_nxt    = gnt;
        end else begin
          hold_nxt = hold_cnt + ARB_HOLD_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      hold_cnt <= '0;
      timeout  <= 1'b0;
      excl     <= '0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      gnt_id   <= id_nxt;
      hold_cnt <= hold_nxt;
      timeout  <= timeout_nxt;
      excl     <= excl_nxt;
    end
  end

  assign gnt_valid = (state == OWNED);

endmodule

// File: tb/tb_req_arbiter.sv
// Bench for req_arbiter (N=4, MAX_HOLD=4): directed vectors, literal checks and a per-cycle reference model.
module tb_req_arbiter;

  localparam int N    = 4;
  localparam int R    = 16;
  localparam int MAXH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [R-1:0]  req = '0;
  logic [R-1:0]  gnt;
  logic [N-1:0]  gnt_id;
  logic          gnt_valid;
  logic          timeout;

  int n_chk  = 0;
  int n_fail = 0;

  req_arbiter #(.N(N), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the resource, for how long, who sat out.
  int m_owner = -1;
  int m_held  = 0;
  int m_excl  = -1;
  int m_ptr   = 0;
  bit m_to    = 1'b0;

  function automatic int pick(input logic [R-1:0] r, input int excl, input int ptr);
    int best = -1;
    int best_lo = -1;
    bit others = 1'b0;
    for (int i = 0; i < R; i++) if (r[i] && i != excl) others = 1'b1;
    for (int i = 0; i < R; i++) begin
      if (r[i] && (!others || i != excl)) begin
        best = i;
        if (i < ptr) best_lo = i;
      end
    end
`ifdef ARB_ROUND_ROBIN_EN
    return (best_lo >= 0) ? best_lo : best;
`else
    return best;
`endif
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_owner = -1; m_held = 0; m_excl = -1; m_ptr = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (req != '0) begin
          m_owner = pick(req, m_excl, m_ptr);
          m_ptr   = m_owner;
          m_held  = 1;
          m_excl  = -1;
        end
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else if (m_held == MAXH) begin
        m_excl  = m_owner;
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_held++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_gnt",       32'(gnt),       (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
    chk("model_gnt_id",    32'(gnt_id),    (m_owner >= 0) ? 32'(m_owner) : 32'd0);
    chk("model_gnt_valid", 32'(gnt_valid), 32'(m_owner >= 0));
    chk("model_timeout",   32'(timeout),   32'(m_to));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    chk("rst_gnt",       32'(gnt),       32'h0);
    chk("rst_gnt_id",    32'(gnt_id),    32'h0);
    chk("rst_gnt_valid", 32'(gnt_valid), 32'h0);
    chk("rst_timeout",   32'(timeout),   32'h0);
    step(); step();
    rst = 1'b0;

    // Idle with no requests stays silent.
    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_gnt_valid", 32'(gnt_valid), 32'h0);
    end

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority, release and one dead cycle.
    req = 16'h8421;
    step(); chk("fp_gnt_c1", 32'(gnt), 32'h8000); chk("fp_id_c1", 32'(gnt_id), 32'd15);
    step();
    step(); req = 16'h0421;
    step(); chk("fp_gnt_c4", 32'(gnt), 32'h0000);
    step(); chk("fp_gnt_c5", 32'(gnt), 32'h0400); chk("fp_id_c5", 32'(gnt_id), 32'd10);
    req = '0;
    step(); step(); step();

    // Hold limit, timeout, exclusion of the expired owner.
    req = 16'h0003;
    for (int c = 1; c <= 4; c++) begin
      step(); chk("to_owner1", 32'(gnt), 32'h0002);
    end
    step(); chk("to_pulse1", 32'(timeout), 32'h1); chk("to_gnt_dead", 32'(gnt), 32'h0);
    step(); chk("to_excl_gnt", 32'(gnt), 32'h0001); chk("to_excl_id", 32'(gnt_id), 32'd0);
    chk("to_pulse_one_cycle", 32'(timeout), 32'h0);
    step(); step(); step();
    step(); chk("to_pulse0", 32'(timeout), 32'h1);
    step(); chk("to_regrant1", 32'(gnt), 32'h0002);
    req = '0;
    step(); step(); step();

    // Release coinciding with the hold limit: no timeout, no exclusion.
    req = 16'h0010;
    step(); step(); step(); step();
    chk("rel_owner4", 32'(gnt), 32'h0010);
    req = 16'h0001;
    step(); chk("rel_no_timeout", 32'(timeout), 32'h0); chk("rel_gnt0", 32'(gnt), 32'h0);
    req = 16'h0011;
    step(); chk("rel_not_excluded", 32'(gnt), 32'h0010);
    req = '0;
    step(); step(); step();
`else
    // Round robin: each owner holds two cycles, drops, re-requests.
    begin
      int order [5] = '{15, 10, 5, 0, 15};
      req = 16'h8421;
      for (int k = 0; k < 5; k++) begin
        int waited = 0;
        step();
        while (!gnt_valid && waited < 10) begin
          step();
          waited++;
        end
        if (!gnt_valid) chk("rr_grant_wait", 32'(gnt_valid), 32'h1);
        chk("rr_order", 32'(gnt_id), 32'(order[k]));
        step();
        req = 16'h8421 & ~(16'h1 << gnt_id);
        step();
        req = 16'h8421;
      end
      req = '0;
      step(); step(); step();
    end
`endif

    // Asynchronous reset mid-ownership, then re-grant after release of reset.
    req = 16'h0010;
    step(); chk("ar_owner", 32'(gnt), 32'h0010);
    #2 rst = 1'b1;
    #1;
    chk("ar_gnt_async",   32'(gnt),       32'h0);
    chk("ar_valid_async", 32'(gnt_valid), 32'h0);
    chk("ar_timeout",     32'(timeout),   32'h0);
    step();
    rst = 1'b0;
    step(); chk("ar_regrant", 32'(gnt), 32'h0010); chk("ar_regrant_id", 32'(gnt_id), 32'd4);
    req = '0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
